// File: rtl/pacman_life_manager_if.sv
// Bundles the per-frame control inputs and life/state outputs of the life manager.
// The slave modport is the life manager; the master modport is the game/collision side driving it.
interface pacman_life_manager_if #(
  parameter int LIVES_W = 3
);
  logic               frame_tick;
  logic               pacman_is_dead;
  logic               game_start;
  logic               extra_life;
  logic [LIVES_W-1:0] lives_remaining;
  logic               freeze;
  logic               respawn;
  logic               death_anim;
  logic               invuln;
  logic               game_over;
  logic [2:0]         state_dbg;

  modport slave (
    input  frame_tick, pacman_is_dead, game_start, extra_life,
    output lives_remaining, freeze, respawn, death_anim, invuln, game_over, state_dbg
  );

  modport master (
    output frame_tick, pacman_is_dead, game_start, extra_life,
    input  lives_remaining, freeze, respawn, death_anim, invuln, game_over, state_dbg
  );
endinterface

// File: rtl/pacman_life_manager.sv
// Pac-Man life manager: confirms deaths, counts lives, sequences death/respawn/invulnerability.
// Optional feature macro PACMAN_EXTRA_LIFE_EN enables bonus lives from extra_life pulses.
module pacman_life_manager #(
  parameter int INIT_LIVES     = 3,
  parameter int MAX_LIVES      = 5,
  parameter int LIVES_W        = 3,
  parameter int CONFIRM_FRAMES = 2,
  parameter int DEATH_FRAMES   = 120,
  parameter int INVULN_FRAMES  = 60
) (
  input logic                   clk,
  input logic                   rst,
  pacman_life_manager_if.slave  bus
);

  localparam int FCNT_MAX = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
  localparam int FCNT_W   = $clog2(FCNT_MAX + 1);
  localparam int CCNT_W   = $clog2(CONFIRM_FRAMES + 1);

  localparam logic [FCNT_W-1:0]  INVULN_LAST  = FCNT_W'(INVULN_FRAMES);
  localparam logic [FCNT_W-1:0]  DEATH_LAST   = FCNT_W'(DEATH_FRAMES);
  localparam logic [CCNT_W-1:0]  CONFIRM_LAST = CCNT_W'(CONFIRM_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_MAX    = LIVES_W'(MAX_LIVES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESPAWN   = 3'd1,
    S_INVULN    = 3'd2,
    S_PLAY      = 3'd3,
    S_DYING     = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CCNT_W-1:0]  confirm_cnt_q, confirm_cnt_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               freeze_q, freeze_d;
  logic               respawn_q, respawn_d;
  logic               death_anim_q, death_anim_d;
  logic               invuln_q, invuln_d;
  logic               game_over_q, game_over_d;

  logic               confirm;
  logic               gain;
  logic [FCNT_W-1:0]  frame_inc;
  logic [CCNT_W-1:0]  confirm_inc;

  assign frame_inc   = frame_cnt_q + 1'b1;
  assign confirm_inc = confirm_cnt_q + 1'b1;

`ifdef PACMAN_EXTRA_LIFE_EN
  assign gain = bus.extra_life && ((state_q == S_INVULN) || (state_q == S_PLAY));
`else
  logic unused_extra_life;
  assign unused_extra_life = bus.extra_life;
  assign gain              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= '0;
      confirm_cnt_q <= '0;
      lives_q       <= LIVES_INIT;
      freeze_q      <= 1'b1;
      respawn_q     <= 1'b0;
      death_anim_q  <= 1'b0;
      invuln_q      <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      confirm_cnt_q <= confirm_cnt_d;
      lives_q       <= lives_d;
      freeze_q      <= freeze_d;
      respawn_q     <= respawn_d;
      death_anim_q  <= death_anim_d;
      invuln_q      <= invuln_d;
      game_over_q   <= game_over_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    confirm_cnt_d = confirm_cnt_q;
    lives_d       = lives_q;
    confirm       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.game_start) begin
          state_d = S_RESPAWN;
          lives_d = LIVES_INIT;
        end
      end
      S_RESPAWN: begin
        frame_cnt_d   = '0;
        confirm_cnt_d = '0;
        state_d       = (INVULN_FRAMES > 0) ? S_INVULN : S_PLAY;
      end
      S_INVULN: begin
        confirm_cnt_d = '0;
        if (bus.frame_tick) begin
          frame_cnt_d = frame_inc;
          if (frame_inc == INVULN_LAST) begin
            frame_cnt_d = '0;
            state_d     = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        // Confirm counter only moves on frame ticks; a low flag on a tick breaks the streak.
        if (bus.frame_tick) begin
          if (!bus.pacman_is_dead) begin
            confirm_cnt_d = '0;
          end else if (confirm_inc == CONFIRM_LAST) begin
            confirm       = 1'b1;
            confirm_cnt_d = '0;
            frame_cnt_d   = '0;
            state_d       = S_DYING;
          end else begin
            confirm_cnt_d = confirm_inc;
          end
        end
      end
      S_DYING: begin
        if (bus.frame_tick) begin
          frame_cnt_d = frame_inc;
          if (frame_inc == DEATH_LAST) begin
            frame_cnt_d = '0;
            state_d     = (lives_q == '0) ? S_GAME_OVER : S_RESPAWN;
          end
        end
      end
      S_GAME_OVER: begin
        if (bus.game_start) begin
          state_d = S_RESPAWN;
          lives_d = LIVES_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A bonus and a death in the same cycle cancel before any saturation.
    if (confirm && !gain) begin
      lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
    end else if (gain && !confirm) begin
      lives_d = (lives_q >= LIVES_MAX) ? LIVES_MAX : lives_q + 1'b1;
    end
  end

  always_comb begin
    freeze_d     = !((state_d == S_INVULN) || (state_d == S_PLAY));
    respawn_d    = (state_d == S_RESPAWN);
    death_anim_d = (state_d == S_DYING);
    invuln_d     = (state_d == S_INVULN);
    game_over_d  = (state_d == S_GAME_OVER);
  end

  assign bus.lives_remaining = lives_q;
  assign bus.freeze          = freeze_q;
  assign bus.respawn         = respawn_q;
  assign bus.death_anim      = death_anim_q;
  assign bus.invuln          = invuln_q;
  assign bus.game_over       = game_over_q;
  assign bus.state_dbg       = state_q;

endmodule
